// File: rtl/usb_slave_access_arbiter.sv
// Grants the shared UHCI register path to the AXI read FSM or the write FIFO head for ACCESS_CYCLES cycles.
// Grant is visible one cycle after arbitration, with one idle turnaround per access; requesters wait and no inputs are backpressured.
module usb_slave_access_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       empty,
  output logic [1:0] Read_en,
  output logic       fifo_rd_en,
  output logic       rd_done,
  output logic       wr_done,
  output logic       busy
);

  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          last_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Done/pop strobes are masked by rst so an access cut short never pops the FIFO.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    last_cycle   = (cnt_q == LAST);
    Read_en      = 2'b00;
    fifo_rd_en   = 1'b0;
    rd_done      = 1'b0;
    wr_done      = 1'b0;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req && (empty || last_grant_q)) begin
          state_d      = READ;
          cnt_d        = '0;
          last_grant_d = 1'b0;
        end else if (!empty) begin
          state_d      = WRITE;
          cnt_d        = '0;
          last_grant_d = 1'b1;
        end
      end
      READ: begin
        Read_en = 2'b01;
        busy    = 1'b1;
        if (last_cycle) begin
          rd_done = !rst;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        Read_en = 2'b10;
        busy    = 1'b1;
        if (last_cycle) begin
          wr_done    = !rst;
          fifo_rd_en = !rst;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/usb_slave_access_arbiter.md
# usb_slave_access_arbiter

Sequencer for the USB slave's shared register-access path. It owns the 2-bit `Read_en` select of the address mux in front of the UHCI decoder. It grants that path either to the AXI read FSM (`Read_en = 01`) or to the head of the write FIFO (`Read_en = 10`), holds the grant for a fixed access window and pops the FIFO on write completion. It sits between the AXI read FSM, the write FIFO and the address mux/decoder.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: cycles `Read_en` is held per access; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `rd_req`  in  1  read request from the AXI read FSM; held high until `rd_done`.
- `empty`  in  1  write FIFO empty flag; low means a write is pending.
- `Read_en`  out  2  mux select: `00` idle, `01` read access, `10` write access; never `11`.
- `fifo_rd_en`  out  1  one-cycle pop strobe to the write FIFO.
- `rd_done`  out  1  one-cycle pulse on the last cycle of a read access.
- `wr_done`  out  1  one-cycle pulse on the last cycle of a write access; coincident with `fifo_rd_en`.
- `busy`  out  1  high while an access is in progress (`Read_en != 00`).

## Operation
- States: IDLE, READ, WRITE. A cycle counter `cnt` runs from 0 to `ACCESS_CYCLES-1`, width `$clog2(ACCESS_CYCLES+1)`.
- A single-bit `last_grant` records the most recent grant: 0 = read, 1 = write.
- IDLE, arbitration from registered state and current inputs:
  - `rd_req` only: go to READ.
  - `!empty` only: go to WRITE.
  - Both pending: grant the side not in `last_grant`.
  - Neither pending: stay in IDLE.
- On entry to READ or WRITE: `cnt` = 0 and `last_grant` updates.
- READ/WRITE: `cnt` increments each cycle. On the cycle where `cnt == ACCESS_CYCLES-1`:
  - READ pulses `rd_done`.
  - WRITE pulses `wr_done` and `fifo_rd_en`.
  - Next state is IDLE in both cases.
- Every access is followed by exactly one IDLE turnaround cycle with `Read_en = 00`. Back-to-back grants are never allowed.
- Outputs are decoded from state/`cnt` only. They are glitch-free and carry no combinational path from `rd_req` or `empty`.
- Exactly one FIFO pop per write grant. The arbiter is the sole consumer, so `empty` cannot rise mid-write.
- If `rd_req` drops mid-read, the requester has violated protocol. The access still completes and `rd_done` still pulses.
- Reset values: state IDLE, `cnt` 0, `last_grant` 1 (read wins the first tie), `Read_en` `00`, and `fifo_rd_en`, `rd_done`, `wr_done`, `busy` all 0.
- `rst` high in any state:
  - The next cycle is IDLE with reset values.
  - An access cut short by reset produces no done pulse and no pop.
  - While `rst` is high, no grant is issued regardless of inputs.

## Timing
- Grant latency: a request visible in IDLE cycle t gives `Read_en` the granted code in cycles t+1 … t+`ACCESS_CYCLES`.
- Done/pop pulses occur in cycle t+`ACCESS_CYCLES`. Cycle t+`ACCESS_CYCLES`+1 is IDLE.
- Per-access period is `ACCESS_CYCLES`+1 cycles. Under continuous contention, reads and writes strictly alternate. Worst-case wait is 2·(`ACCESS_CYCLES`+1) cycles.
- Requester handshake:
  - The read FSM samples `rd_done` at the clock edge ending the last access cycle and drives `rd_req` low in the following IDLE cycle. A stale request is therefore never re-granted.
  - The FIFO updates `empty` on the edge that consumes `fifo_rd_en`, so the IDLE cycle sees the new value.
- `rst` deasserted in cycle r means cycle r is the first arbitration cycle. The earliest grant is in r+1.

## Test plan
All scenarios use `ACCESS_CYCLES=2` unless stated.
- Reset: hold `rst` 3 cycles with `rd_req=1`, `empty=0` → `Read_en=00` and all strobes 0 throughout; `Read_en=01` in the first cycle after the first non-reset cycle.
- Single read: `rd_req` rises in IDLE cycle 0 → `Read_en=01` in cycles 1–2; `rd_done=1` only in cycle 2; `Read_en=00` in cycle 3; no `fifo_rd_en`.
- Write drain: 3 FIFO entries, `rd_req=0` → `Read_en=10` in cycles 1–2, 4–5, 7–8; `fifo_rd_en` pulses in cycles 2, 5, 8; exactly 3 pops, then idle.
- Contention: `rd_req` held and FIFO kept non-empty from reset release → grant sequence R, W, R, W; `Read_en` never `11`; period 3 cycles.
- Reset mid-write: assert `rst` in cycle 1 of a WRITE → no `wr_done`, no `fifo_rd_en`; `Read_en=00` next cycle; FIFO count unchanged.
- `ACCESS_CYCLES=1`: continuous `rd_req` → `Read_en=01` every other cycle; `rd_done` each grant cycle; period 2 cycles.
